// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding four byte requesters into one UART transmitter.
// All outputs are registered; a watchdog aborts transfers whose done pulse never arrives.
module uart_tx_arbiter #(
    parameter logic [19:0] TIMEOUT = 20'd100000
) (
    input  logic        clk_50M,
    input  logic        reset,
    input  logic [3:0]  req_in,
    input  logic [31:0] data_in,
    output logic [3:0]  ack_out,
    output logic [1:0]  grant_out,
    output logic        busy_out,
    output logic [7:0]  tx_data_out,
    output logic        tx_start_out,
    input  logic        tx_done_in,
    output logic        timeout_out
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_DONE
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_rr;
    logic [1:0]  w_rr_nxt;
    logic [19:0] r_wd;
    logic [19:0] w_wd_nxt;
    logic [3:0]  r_ack;
    logic [3:0]  w_ack_nxt;
    logic [1:0]  r_grant;
    logic [1:0]  w_grant_nxt;
    logic        r_busy;
    logic        w_busy_nxt;
    logic [7:0]  r_txd;
    logic [7:0]  w_txd_nxt;
    logic        r_txs;
    logic        w_txs_nxt;
    logic        r_tmo;
    logic        w_tmo_nxt;
    logic [1:0]  w_win;
    logic        w_found;
    logic        w_expired;

    // First pending requester at or above the pointer, wrapping 3->0.
    always_comb begin
        w_win   = r_rr;
        w_found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (!w_found && req_in[r_rr + 2'(k)]) begin
                w_win   = r_rr + 2'(k);
                w_found = 1'b1;
            end
        end
    end

    assign w_expired = (r_wd == TIMEOUT - 20'd1);

    always_comb begin
        w_state_nxt = r_state;
        w_rr_nxt    = r_rr;
        w_wd_nxt    = r_wd;
        w_ack_nxt   = 4'b0000;
        w_grant_nxt = r_grant;
        w_busy_nxt  = r_busy;
        w_txd_nxt   = r_txd;
        w_txs_nxt   = 1'b0;
        w_tmo_nxt   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nxt = START;
                    w_ack_nxt   = 4'b0001 << w_win;
                    w_grant_nxt = w_win;
                    w_busy_nxt  = 1'b1;
                    w_txd_nxt   = data_in[{w_win, 3'b000} +: 8];
                end
            end
            START: begin
                w_state_nxt = WAIT_DONE;
                w_txs_nxt   = 1'b1;
                w_wd_nxt    = 20'd0;
            end
            WAIT_DONE: begin
                // A done pulse on the expiry cycle counts as a normal completion.
                if (tx_done_in || w_expired) begin
                    w_state_nxt = IDLE;
                    w_busy_nxt  = 1'b0;
                    w_rr_nxt    = r_grant + 2'd1;
                    w_tmo_nxt   = !tx_done_in;
                end else begin
                    w_wd_nxt = r_wd + 20'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_50M) begin
        if (reset) begin
            r_state <= IDLE;
            r_rr    <= 2'd0;
            r_wd    <= 20'd0;
            r_ack   <= 4'b0000;
            r_grant <= 2'd0;
            r_busy  <= 1'b0;
            r_txd   <= 8'h00;
            r_txs   <= 1'b0;
            r_tmo   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_rr    <= w_rr_nxt;
            r_wd    <= w_wd_nxt;
            r_ack   <= w_ack_nxt;
            r_grant <= w_grant_nxt;
            r_busy  <= w_busy_nxt;
            r_txd   <= w_txd_nxt;
            r_txs   <= w_txs_nxt;
            r_tmo   <= w_tmo_nxt;
        end
    end

    assign ack_out      = r_ack;
    assign grant_out    = r_grant;
    assign busy_out     = r_busy;
    assign tx_data_out  = r_txd;
    assign tx_start_out = r_txs;
    assign timeout_out  = r_tmo;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: arbitration order, handshake timing,
// watchdog expiry and reset behaviour, built with a 16-cycle watchdog.
module tb_uart_tx_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  ack;
    logic [1:0]  grant;
    logic        busy;
    logic [7:0]  txd;
    logic        txs;
    logic        done;
    logic        tmo;

    int nchk = 0;
    int nerr = 0;

    localparam logic [31:0] DATA = 32'h4441_2211;

    uart_tx_arbiter #(.TIMEOUT(20'd16)) dut (
        .clk_50M     (clk),
        .reset       (reset),
        .req_in      (req),
        .data_in     (data),
        .ack_out     (ack),
        .grant_out   (grant),
        .busy_out    (busy),
        .tx_data_out (txd),
        .tx_start_out(txs),
        .tx_done_in  (done),
        .timeout_out (tmo)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".ack"}, {28'd0, ack}, 32'd0);
        check({tag, ".grant"}, {30'd0, grant}, 32'd0);
        check({tag, ".busy"}, {31'd0, busy}, 32'd0);
        check({tag, ".txd"}, {24'd0, txd}, 32'd0);
        check({tag, ".txs"}, {31'd0, txs}, 32'd0);
        check({tag, ".tmo"}, {31'd0, tmo}, 32'd0);
    endtask

    // Grant with the current req, then start, then done; req is left as given.
    task automatic xfer(input string tag, input logic [3:0] r,
                        input logic [1:0] g, input logic [7:0] d);
        req = r;
        step();
        check({tag, ".grant"}, {30'd0, grant}, {30'd0, g});
        check({tag, ".ack"}, {28'd0, ack}, 32'd1 << g);
        check({tag, ".txd"}, {24'd0, txd}, {24'd0, d});
        check({tag, ".busy"}, {31'd0, busy}, 32'd1);
        step();
        check({tag, ".txs"}, {31'd0, txs}, 32'd1);
        check({tag, ".ack1"}, {28'd0, ack}, 32'd0);
        step();
        check({tag, ".txs1"}, {31'd0, txs}, 32'd0);
        done = 1'b1;
        step();
        done = 1'b0;
        check({tag, ".busy_end"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [1:0] order [5];
        logic [7:0] bytes [4];
        order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        bytes = '{8'h11, 8'h22, 8'h41, 8'h44};

        reset = 1'b1;
        req   = 4'b0000;
        data  = DATA;
        done  = 1'b0;
        step();
        step();
        check_idle_outputs("reset");
        reset = 1'b0;

        // Single request, data change after grant must not reach txd.
        req = 4'b0100;
        step();
        check("single.ack", {28'd0, ack}, 32'h4);
        check("single.txd", {24'd0, txd}, 32'h41);
        check("single.txs0", {31'd0, txs}, 32'd0);
        req  = 4'b0000;
        data = 32'hFFFF_FFFF;
        step();
        check("single.txs", {31'd0, txs}, 32'd1);
        check("single.hold", {24'd0, txd}, 32'h41);
        step();
        check("single.txs_off", {31'd0, txs}, 32'd0);
        check("single.busy", {31'd0, busy}, 32'd1);
        data = DATA;
        done = 1'b1;
        step();
        done = 1'b0;
        check("single.busy_low", {31'd0, busy}, 32'd0);

        reset = 1'b1;
        step();
        reset = 1'b0;

        for (int i = 0; i < 5; i++)
            xfer($sformatf("rr%0d", i), 4'b1111, order[i], bytes[order[i]]);

        // Pointer now 1; requester 1 moves it to 2, then 0 must win over 1.
        xfer("pre_skip", 4'b0010, 2'd1, 8'h22);
        xfer("skip0", 4'b0011, 2'd0, 8'h11);
        xfer("skip1", 4'b0011, 2'd1, 8'h22);

        // Watchdog: pointer is 2, requester 2 wins and never completes.
        req = 4'b0100;
        step();
        check("wd.grant", {30'd0, grant}, 32'd2);
        req = 4'b0000;
        step();
        for (int k = 1; k < 16; k++) begin
            step();
            check($sformatf("wd.quiet%0d", k), {31'd0, tmo}, 32'd0);
        end
        step();
        check("wd.tmo", {31'd0, tmo}, 32'd1);
        check("wd.busy", {31'd0, busy}, 32'd0);
        step();
        check("wd.tmo_off", {31'd0, tmo}, 32'd0);
        xfer("wd.rr", 4'b0101, 2'd0, 8'h11);

        // Done on the expiry cycle wins; pointer is 1 now.
        req = 4'b0010;
        step();
        check("exp.grant", {30'd0, grant}, 32'd1);
        req = 4'b0000;
        step();
        for (int k = 1; k < 16; k++) step();
        done = 1'b1;
        step();
        done = 1'b0;
        check("exp.tmo", {31'd0, tmo}, 32'd0);
        check("exp.busy", {31'd0, busy}, 32'd0);
        step();
        check("exp.tmo_after", {31'd0, tmo}, 32'd0);

        // Done in IDLE and START is ignored.
        done = 1'b1;
        step();
        done = 1'b0;
        check("idle_done.busy", {31'd0, busy}, 32'd0);
        check("idle_done.ack", {28'd0, ack}, 32'd0);
        req = 4'b0100;
        step();
        check("start_done.grant", {30'd0, grant}, 32'd2);
        req  = 4'b0000;
        done = 1'b1;
        step();
        done = 1'b0;
        check("start_done.txs", {31'd0, txs}, 32'd1);
        step();
        check("start_done.busy", {31'd0, busy}, 32'd1);
        done = 1'b1;
        step();
        done = 1'b0;
        check("start_done.end", {31'd0, busy}, 32'd0);

        // Reset while waiting for done, with requester 3 pending.
        req = 4'b0001;
        step();
        check("rst.grant", {30'd0, grant}, 32'd0);
        step();
        step();
        req   = 4'b1000;
        reset = 1'b1;
        step();
        check_idle_outputs("rst.a");
        done = 1'b1;
        step();
        check_idle_outputs("rst.b");
        reset = 1'b0;
        step();
        done = 1'b0;
        check("rst.grant3", {30'd0, grant}, 32'd3);
        check("rst.ack3", {28'd0, ack}, 32'h8);
        check("rst.txd3", {24'd0, txd}, 32'h44);
        step();
        check("rst.txs", {31'd0, txs}, 32'd1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 20'd100000, WAIT_DONE watchdog limit in clk_50M cycles.
REQ-002 Port: clk_50M  input  1  system clock; all logic on its rising edge.
REQ-003 Port: reset  input  1  reset; synchronous and active-high.
REQ-004 Port: req_in  input  4  per-requester request level; bit i = requester i has a byte pending.
REQ-005 Port: data_in  input  32  requester bytes; requester i at [8i+7:8i], held stable while req_in[i]=1.
REQ-006 Port: ack_out  output  4  one-cycle pulse to requester i when its byte is latched.
REQ-007 Port: grant_out  output  2  index of current/last granted requester.
REQ-008 Port: busy_out  output  1  high from grant until return to IDLE.
REQ-009 Port: tx_data_out  output  8  byte to the UART transmitter's data input.
REQ-010 Port: tx_start_out  output  1  one-cycle start pulse to the UART transmitter.
REQ-011 Port: tx_done_in  input  1  one-cycle done pulse from the UART transmitter.
REQ-012 Port: timeout_out  output  1  one-cycle pulse when the watchdog aborts a transfer.

Function
REQ-013 FSM states IDLE, START, WAIT_DONE; all outputs registered.
REQ-014 IDLE, req_in != 0 at edge N: winner = first set bit scanning from rr_ptr upward, wrapping 3->0.
REQ-015 At N+1: tx_data_out = winner's data_in byte, ack_out = one-hot winner, grant_out = winner, busy_out = 1, state START.
REQ-016 START: tx_start_out = 1 for exactly one cycle (N+2); next state WAIT_DONE.
REQ-017 tx_data_out holds its value from grant until the next grant; unchanged by req_in/data_in changes.
REQ-018 WAIT_DONE, tx_done_in = 1: next state IDLE, busy_out = 0, rr_ptr = grant_out + 1 (mod 4).
REQ-019 tx_done_in is ignored in IDLE and START.
REQ-020 20-bit watchdog cleared on entering WAIT_DONE, +1 per WAIT_DONE cycle.
REQ-021 Watchdog = TIMEOUT-1 without tx_done_in: timeout_out pulses one cycle, state IDLE, busy_out = 0, rr_ptr advances as in REQ-018.
REQ-022 tx_done_in in the same cycle the watchdog expires: normal completion wins; no timeout_out pulse.
REQ-023 Requests during START/WAIT_DONE are not latched; they are arbitrated only in IDLE.
REQ-024 req_in[i] dropped before grant: no ack, no transfer for i.
REQ-025 req_in[i] still high at the next IDLE edge: treated as a new byte, subject to rotation.
REQ-026 Back-to-back throughput: done at edge M -> IDLE at M+1 -> next grant at M+2.
REQ-027 ack_out is never asserted for more than one bit or more than one cycle per grant.

Reset
REQ-028 reset=1 at a clk_50M edge: state IDLE, rr_ptr = 0, watchdog = 0.
REQ-029 Reset values: ack_out = 0, grant_out = 0, busy_out = 0, tx_data_out = 8'h00, tx_start_out = 0, timeout_out = 0.
REQ-030 reset mid-transfer (START or WAIT_DONE) aborts with no ack/start/timeout pulse; a later tx_done_in is ignored.
REQ-031 reset has priority over all other inputs in the same cycle.

Verification
REQ-032 Single req: req_in=4'b0100, data_in[23:16]=8'h41 -> ack_out=4'b0100 and tx_data_out=8'h41 next cycle, tx_start_out one cycle later, busy_out low cycle after tx_done_in.
REQ-033 Round-robin: req_in=4'b1111 held, done returned each time -> grant order 0,1,2,3,0; each ack_out one-hot.
REQ-034 Skip: rr_ptr=2, req_in=4'b0011 -> grant 0, then 1.
REQ-035 Watchdog: TIMEOUT=20'd16, no tx_done_in -> timeout_out pulse 16 cycles after entering WAIT_DONE, IDLE next, rr_ptr advanced.
REQ-036 Boundary: tx_done_in on the expiry cycle -> no timeout_out; tx_done_in in IDLE/START -> no state change.
REQ-037 Reset in WAIT_DONE with req_in=4'b1000 -> all outputs at reset values; next grant goes to requester 3 only after reset is deasserted.
